// File: rtl/ped_button_conditioner.sv
// ped_button_conditioner
// Conditions raw pedestrian push-buttons for the traffic light FSM.
// Each channel has a 2-flop synchronizer, a counter-based debounce FSM and
// press-edge detection. It produces these outputs:
//   - a one-cycle press pulse per channel
//   - a debounced level per channel
//   - the OR of the pulses
// Every output is registered.
//
// Optional feature: define STUCK_DETECT_EN to enable per-channel stuck-button
// detection. A channel is flagged stuck once it has been held longer than
// STUCK_SEC seconds. When the macro is undefined, o_ped_stuck is tied to 0.

module ped_button_conditioner #(
    parameter int CYCLES_PER_SEC = 125000000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int NUM_BUTTONS    = 4,
    parameter int STUCK_SEC      = 30
) (
    input  logic                   clk,
    input  logic                   i_maintenance,
    input  logic [NUM_BUTTONS-1:0] i_ped_raw,
    output logic [NUM_BUTTONS-1:0] o_ped_buttons,
    output logic [NUM_BUTTONS-1:0] o_ped_level,
    output logic                   o_ped_any,
    output logic [NUM_BUTTONS-1:0] o_ped_stuck
);

    // Number of consecutive synchronized samples a new level must hold.
    localparam int DB_CYCLES = (CYCLES_PER_SEC / 1000) * DEBOUNCE_MS;
    // Wide enough to hold DB_CYCLES. The counter resets at its terminal
    // value, so it never wraps.
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef STUCK_DETECT_EN
    // Compute in 64 bits: the product overflows a signed 32-bit int at
    // default settings. The result itself fits in 32 unsigned bits.
    localparam logic [31:0] STUCK_LIMIT =
        32'(64'(STUCK_SEC) * 64'(CYCLES_PER_SEC) - 64'd1);
`endif

    // Elaboration-time sanity checks on the configuration.
    if (DB_CYCLES < 2) begin : g_bad_debounce
        $error("ped_button_conditioner: DB_CYCLES must be at least 2");
    end
    if (STUCK_SEC < 1) begin : g_bad_stuck
        $error("ped_button_conditioner: STUCK_SEC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_BUTTONS-1:0] sync_q1;
    logic [NUM_BUTTONS-1:0] sync_q2;
    logic [NUM_BUTTONS-1:0] press_vec;
    logic [NUM_BUTTONS-1:0] level_vec;
    logic [NUM_BUTTONS-1:0] stuck_vec;

    // Two-flop synchronizer. These are the only flops that see the raw pins.
    // NOTE: sequential state always uses non-blocking assignments, so that
    // each flop samples its neighbour's pre-edge value and the chain behaves
    // as a true shift.
    always_ff @(posedge clk) begin
        if (i_maintenance) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= i_ped_raw;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             press;
        logic             s;

        assign s = sync_q2[i];

        // Debounce FSM for this channel. It raises press for exactly one
        // cycle on the PRESS_WAIT -> PRESSED transition and tracks the
        // debounced level.
        // NOTE: the synchronous reset branch covers every flop in this block,
        // including the counter. Pending counts are then discarded, and a
        // button still held after reset is seen as a fresh press.
        always_ff @(posedge clk) begin
            if (i_maintenance) begin
                state <= IDLE;
                cnt   <= '0;
                level <= 1'b0;
                press <= 1'b0;
            end else begin
                press <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_TERM) begin
                            state <= PRESSED;
                            cnt   <= '0;
                            press <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!s) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s) begin
                            // A bounce back to pressed: resume the press
                            // without issuing a second pulse.
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_TERM) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign press_vec[i] = press;
        assign level_vec[i] = level;

`ifdef STUCK_DETECT_EN
        logic [31:0] hold;
        logic        stuck;

        // Hold-time counter for stuck detection. It runs while the channel
        // is pressed or settling from release, and saturates at the limit.
        // The sticky flag clears only through IDLE or reset.
        always_ff @(posedge clk) begin
            if (i_maintenance) begin
                hold  <= '0;
                stuck <= 1'b0;
            end else if (state == IDLE) begin
                hold  <= '0;
                stuck <= 1'b0;
            end else if (state == PRESSED || state == RELEASE_WAIT) begin
                if (hold == STUCK_LIMIT) begin
                    stuck <= 1'b1;
                end else begin
                    hold  <= hold + 32'd1;
                end
            end
        end

        assign stuck_vec[i] = stuck;
`else
        assign stuck_vec[i] = 1'b0;
`endif
    end

    // Output registers. The pulses and their OR are registered in the same
    // cycle. A stuck channel masks its debounced level.
    always_ff @(posedge clk) begin
        if (i_maintenance) begin
            o_ped_buttons <= '0;
            o_ped_level   <= '0;
            o_ped_any     <= 1'b0;
            o_ped_stuck   <= '0;
        end else begin
            o_ped_buttons <= press_vec;
            o_ped_level   <= level_vec & ~stuck_vec;
            o_ped_any     <= |press_vec;
            o_ped_stuck   <= stuck_vec;
        end
    end

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Self-checking bench for ped_button_conditioner.
// Bench settings: CYCLES_PER_SEC=4000 and DEBOUNCE_MS=5, giving DB_CYCLES=20.
// Outputs are observed 1 ns after each rising edge. Index e counts the edges
// after a stimulus change; e = 0 is the first edge that samples the new value.
// A press or release therefore appears on the outputs at e = DB_CYCLES + 2 = 22.
// Define STUCK_DETECT_EN to exercise the stuck-button feature
// (STUCK_SEC=1, i.e. a limit of 4000 cycles).

module tb_ped_button_conditioner;

    localparam int NB  = 4;
    localparam int LAT = 22;

    logic          clk;
    logic          i_maintenance;
    logic [NB-1:0] i_ped_raw;
    logic [NB-1:0] o_ped_buttons;
    logic [NB-1:0] o_ped_level;
    logic          o_ped_any;
    logic [NB-1:0] o_ped_stuck;

    int tests_run    = 0;
    int tests_failed = 0;

    ped_button_conditioner #(
        .CYCLES_PER_SEC(4000),
        .DEBOUNCE_MS   (5),
        .NUM_BUTTONS   (NB),
        .STUCK_SEC     (1)
    ) dut (
        .clk          (clk),
        .i_maintenance(i_maintenance),
        .i_ped_raw    (i_ped_raw),
        .o_ped_buttons(o_ped_buttons),
        .o_ped_level  (o_ped_level),
        .o_ped_any    (o_ped_any),
        .o_ped_stuck  (o_ped_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observes a press window and records:
    //   - the first pulse edge, the pulse count and the pulse value
    //   - o_ped_any in the pulse cycle, and whether o_ped_any always equals
    //     the OR of o_ped_buttons
    //   - the first edge at which all masked levels are high
    task automatic watch_press(input int cycles, input logic [NB-1:0] mask,
                               output int first_pulse, output int pulses,
                               output logic [NB-1:0] pulse_val,
                               output logic any_at_pulse, output logic any_ok,
                               output int first_level);
        first_pulse  = -1;
        pulses       = 0;
        pulse_val    = '0;
        any_at_pulse = 1'b0;
        any_ok       = 1'b1;
        first_level  = -1;
        for (int e = 0; e < cycles; e++) begin
            step();
            if (o_ped_any !== (|o_ped_buttons)) any_ok = 1'b0;
            if ((o_ped_buttons & mask) != '0) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse  = e;
                    pulse_val    = o_ped_buttons;
                    any_at_pulse = o_ped_any;
                end
            end
            if (first_level < 0 && (o_ped_level & mask) == mask) first_level = e;
        end
    endtask

    // Observes a release window. Records the first edge at which the masked
    // levels are all low, and counts any pulse cycles.
    task automatic watch_release(input int cycles, input logic [NB-1:0] mask,
                                 output int first_low, output int pulses);
        first_low = -1;
        pulses    = 0;
        for (int e = 0; e < cycles; e++) begin
            step();
            if (o_ped_buttons != '0) pulses++;
            if (first_low < 0 && (o_ped_level & mask) == '0) first_low = e;
        end
    endtask

    task automatic test_reset();
        int fp, np, fl, fl0, np2;
        logic [NB-1:0] pv;
        logic aat, aok;
        i_maintenance = 1'b1;
        i_ped_raw     = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if ({o_ped_buttons, o_ped_level, o_ped_any, o_ped_stuck} !== 13'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got btn=%h lvl=%h any=%b stuck=%h, expected all 0",
                         c, o_ped_buttons, o_ped_level, o_ped_any, o_ped_stuck);
            end
        end
        i_maintenance = 1'b0;
        watch_press(60, 4'hF, fp, np, pv, aat, aok, fl);
        tests_run++;
        if (fp !== LAT) begin
            tests_failed++;
            $display("FAIL reset_release_latency: got %0d expected %0d", fp, LAT);
        end
        tests_run++;
        if (np !== 1 || pv !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_release_pulse: got count=%0d value=%h expected count=1 value=f", np, pv);
        end
        tests_run++;
        if (aat !== 1'b1 || aok !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_any: got at_pulse=%b consistent=%b expected 1 1", aat, aok);
        end
        i_ped_raw = 4'h0;
        watch_release(40, 4'hF, fl0, np2);
        tests_run++;
        if (fl0 !== LAT || np2 !== 0) begin
            tests_failed++;
            $display("FAIL reset_release_level_fall: got latency=%0d pulses=%0d expected %0d 0", fl0, np2, LAT);
        end
    endtask

    task automatic test_glitch();
        logic [NB-1:0] seen_btn, seen_lvl;
        logic seen_any;
        seen_btn = '0;
        seen_lvl = '0;
        seen_any = 1'b0;
        i_ped_raw = 4'b0001;
        for (int e = 0; e < 60; e++) begin
            if (e == 15) i_ped_raw = 4'b0000;
            step();
            seen_btn |= o_ped_buttons;
            seen_lvl |= o_ped_level;
            seen_any |= o_ped_any;
        end
        tests_run++;
        if (seen_btn !== 4'b0000) begin
            tests_failed++;
            $display("FAIL glitch_buttons: got %h expected 0", seen_btn);
        end
        tests_run++;
        if (seen_lvl !== 4'b0000) begin
            tests_failed++;
            $display("FAIL glitch_level: got %h expected 0", seen_lvl);
        end
        tests_run++;
        if (seen_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_any: got %b expected 0", seen_any);
        end
    endtask

    task automatic test_clean_press();
        int fp, np, fl, fl0, np2;
        logic [NB-1:0] pv;
        logic aat, aok;
        i_ped_raw = 4'b0100;
        watch_press(100, 4'b0100, fp, np, pv, aat, aok, fl);
        tests_run++;
        if (fp !== LAT || np !== 1 || pv !== 4'b0100) begin
            tests_failed++;
            $display("FAIL clean_press_pulse: got at=%0d count=%0d value=%h expected at=%0d count=1 value=4",
                     fp, np, pv, LAT);
        end
        tests_run++;
        if (fl !== LAT) begin
            tests_failed++;
            $display("FAIL clean_press_level_rise: got %0d expected %0d", fl, LAT);
        end
        i_ped_raw = 4'b0000;
        watch_release(40, 4'b0100, fl0, np2);
        tests_run++;
        if (fl0 !== LAT || np2 !== 0) begin
            tests_failed++;
            $display("FAIL clean_press_level_fall: got latency=%0d pulses=%0d expected %0d 0", fl0, np2, LAT);
        end
    endtask

    task automatic test_bounce();
        int fp, np, fl, fl0, np2, bounce_pulses;
        logic [NB-1:0] pv;
        logic aat, aok, level_held;
        i_ped_raw = 4'b0010;
        watch_press(40, 4'b0010, fp, np, pv, aat, aok, fl);
        tests_run++;
        if (fp !== LAT || np !== 1) begin
            tests_failed++;
            $display("FAIL bounce_first_press: got at=%0d count=%0d expected at=%0d count=1", fp, np, LAT);
        end
        bounce_pulses = 0;
        level_held    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_ped_raw = (k % 2 == 1) ? 4'b0010 : 4'b0000;
            for (int c = 0; c < 5; c++) begin
                step();
                if (o_ped_buttons != '0) bounce_pulses++;
                if (o_ped_level[1] !== 1'b1) level_held = 1'b0;
            end
        end
        i_ped_raw = 4'b0000;
        watch_release(40, 4'b0010, fl0, np2);
        tests_run++;
        if (bounce_pulses !== 0 || np2 !== 0) begin
            tests_failed++;
            $display("FAIL bounce_extra_pulse: got %0d+%0d expected 0", bounce_pulses, np2);
        end
        tests_run++;
        if (level_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce_level_held: got %b expected 1", level_held);
        end
        tests_run++;
        if (fl0 !== LAT) begin
            tests_failed++;
            $display("FAIL bounce_level_fall: got %0d expected %0d", fl0, LAT);
        end
    endtask

    task automatic test_simultaneous();
        int fp, np, fl, fl0, np2;
        logic [NB-1:0] pv;
        logic aat, aok;
        i_ped_raw = 4'b1001;
        watch_press(40, 4'b1001, fp, np, pv, aat, aok, fl);
        tests_run++;
        if (fp !== LAT || np !== 1 || pv !== 4'b1001) begin
            tests_failed++;
            $display("FAIL simultaneous_pulse: got at=%0d count=%0d value=%h expected at=%0d count=1 value=9",
                     fp, np, pv, LAT);
        end
        tests_run++;
        if (aat !== 1'b1 || aok !== 1'b1) begin
            tests_failed++;
            $display("FAIL simultaneous_any: got at_pulse=%b consistent=%b expected 1 1", aat, aok);
        end
        i_ped_raw = 4'b0000;
        watch_release(40, 4'b1001, fl0, np2);
        tests_run++;
        if (fl0 !== LAT) begin
            tests_failed++;
            $display("FAIL simultaneous_level_fall: got %0d expected %0d", fl0, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int fp, np, fl, fl0, np2;
        logic [NB-1:0] pv;
        logic aat, aok;
        i_ped_raw = 4'b1000;
        watch_press(40, 4'b1000, fp, np, pv, aat, aok, fl);
        i_maintenance = 1'b1;
        step();
        tests_run++;
        if (o_ped_level !== 4'b0000 || o_ped_buttons !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_mid_clear: got lvl=%h btn=%h expected 0 0", o_ped_level, o_ped_buttons);
        end
        i_maintenance = 1'b0;
        watch_press(40, 4'b1000, fp, np, pv, aat, aok, fl);
        tests_run++;
        if (fp !== LAT || np !== 1) begin
            tests_failed++;
            $display("FAIL reset_mid_new_press: got at=%0d count=%0d expected at=%0d count=1", fp, np, LAT);
        end
        i_ped_raw = 4'b0000;
        watch_release(40, 4'b1000, fl0, np2);
    endtask

`ifdef STUCK_DETECT_EN
    task automatic test_stuck();
        int first_stuck, first_clear, pulses;
        logic [NB-1:0] stuck_end;
        logic lvl_end;
        first_stuck = -1;
        i_ped_raw   = 4'b0010;
        for (int e = 0; e < 5000; e++) begin
            step();
            if (first_stuck < 0 && o_ped_stuck[1] === 1'b1) first_stuck = e;
        end
        stuck_end = o_ped_stuck;
        lvl_end   = o_ped_level[1];
        tests_run++;
        if (first_stuck < 4000 || first_stuck > 4030) begin
            tests_failed++;
            $display("FAIL stuck_onset: got %0d expected within 4000..4030", first_stuck);
        end
        tests_run++;
        if (stuck_end !== 4'b0010 || lvl_end !== 1'b0) begin
            tests_failed++;
            $display("FAIL stuck_flag: got stuck=%h lvl1=%b expected 2 0", stuck_end, lvl_end);
        end
        i_ped_raw   = 4'b0000;
        first_clear = -1;
        pulses      = 0;
        for (int e = 0; e < 40; e++) begin
            step();
            if (o_ped_buttons != '0) pulses++;
            if (first_clear < 0 && o_ped_stuck[1] === 1'b0) first_clear = e;
        end
        tests_run++;
        if (first_clear < LAT || first_clear > LAT + 3 || pulses !== 0) begin
            tests_failed++;
            $display("FAIL stuck_clear: got at=%0d pulses=%0d expected at within 22..25 and 0 pulses",
                     first_clear, pulses);
        end
    endtask
`else
    task automatic test_stuck_off();
        logic [NB-1:0] seen;
        int fl0, np2;
        seen = '0;
        i_ped_raw = 4'b0010;
        for (int e = 0; e < 300; e++) begin
            step();
            seen |= o_ped_stuck;
        end
        tests_run++;
        if (seen !== 4'b0000 || o_ped_level !== 4'b0010) begin
            tests_failed++;
            $display("FAIL stuck_off: got stuck=%h lvl=%h expected 0 2", seen, o_ped_level);
        end
        i_ped_raw = 4'b0000;
        watch_release(40, 4'b0010, fl0, np2);
    endtask
`endif

    initial begin
        i_maintenance = 1'b1;
        i_ped_raw     = '0;
        test_reset();
        test_glitch();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
`ifdef STUCK_DETECT_EN
        test_stuck();
`else
        test_stuck_off();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
